// File: rtl/sumador_serie_ctrl.sv
// sumador_serie_ctrl: adds two 8*NBYTES-bit operands one byte per clock through a single
// external 8-bit adder. Define SUMADOR_SERIE_OVF_EN to add the registered overflow output ovf.
module sumador_serie_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
  output logic                  ready,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
`ifdef SUMADOR_SERIE_OVF_EN
  output logic                  ovf,
`endif
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    res;
  logic [W-1:0]    res_nxt;
  logic            c_reg;
  logic [IW-1:0]   idx;
  logic            accept;
  logic            last_byte;

  // Handshake: an op is taken on a rising edge with start && ready (ready only in IDLE);
  // done is a one-cycle pulse in the cycle where sum/cout first hold the new result.
  assign accept    = start && (state == IDLE);
  assign last_byte = (state == RUN) && (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    add_a     = 8'd0;
    add_b     = 8'd0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        add_a   = a_sh[7:0];
        add_b   = b_sh[7:0];
        add_cin = c_reg;
        if (idx == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result being assembled, with the current adder byte merged in at position idx.
  always_comb begin
    res_nxt = res;
    if (state == RUN) begin
      res_nxt[{idx, 3'b000} +: 8] = add_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      c_reg <= 1'b0;
      idx   <= '0;
      res   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= op_a;
      b_sh  <= op_b;
      c_reg <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      res   <= res_nxt;
      c_reg <= add_cout;
      a_sh  <= a_sh >> 8;
      b_sh  <= b_sh >> 8;
      idx   <= idx + 1'b1;
      // sum/cout keep the previous result until the top byte is in.
      if (last_byte) begin
        sum  <= res_nxt;
        cout <= add_cout;
`ifdef SUMADOR_SERIE_OVF_EN
        ovf  <= (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
`endif
      end
    end
  end

  a_done_single: assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_ready_done:  assert property (@(posedge clk) disable iff (rst) !(ready && done));

endmodule
